// File: rtl/fp32_defs.sv
// Shared binary32 definitions: field layout, exponent constants, canonical NaN and flag bit positions.
package fp32_defs;

   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int MANT_W   = 24;
   localparam int PROD_W   = 48;
   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;

   localparam logic [31:0] QNAN_DEF = 32'h7FC0_0000;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   function automatic logic [31:0] fp32_pack(input logic sign, input logic [EXP_W-1:0] exp,
                                             input logic [FRAC_W-1:0] frac);
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational binary32 operand classifier; denormals are treated as zero.
module fp32_classify
   import fp32_defs::*;
(
   input  logic [31:0] op,
   output logic        is_zero,
   output logic        is_inf,
   output logic        is_nan
);

   fp32_t f;

   assign f       = op;
   assign is_zero = (f.exp == '0);
   assign is_inf  = (f.exp == '1) && (f.frac == '0);
   assign is_nan  = (f.exp == '1) && (f.frac != '0);

endmodule

// File: rtl/fp_mul_norm_round.sv
// Binary32 multiplier back end: classify/normalize, then round/pack, as a two-stage
// valid/ready pipeline that stalls as a whole.
module fp_mul_norm_round
   import fp32_defs::*;
#(
   parameter bit          ROUND_EN = 1'b1,
   parameter logic [31:0] QNAN     = QNAN_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [47:0] in_prod,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_flags
);

   function automatic logic round_up(input logic [MANT_W-1:0] mant, input logic guard,
                                     input logic sticky);
      return ROUND_EN && guard && (sticky || mant[0]);
   endfunction

   // Saturating pack: returns {result, flags} for a finite, non-special product.
   function automatic logic [35:0] saturate_pack(input logic sign, input logic signed [9:0] exp,
                                                 input logic [MANT_W-1:0] mant, input logic inexact);
      logic [3:0] flg;
      flg = '0;
      if (exp >= 10'sd255) begin
         flg[FLG_OVF] = 1'b1;
         flg[FLG_INX] = 1'b1;
         return {fp32_pack(sign, 8'hFF, '0), flg};
      end else if (exp <= 10'sd0) begin
         flg[FLG_UNF] = 1'b1;
         flg[FLG_INX] = 1'b1;
         return {fp32_pack(sign, 8'h00, '0), flg};
      end
      flg[FLG_INX] = inexact;
      return {fp32_pack(sign, exp[7:0], mant[FRAC_W-1:0]), flg};
   endfunction

   fp32_t fa, fb;
   logic  a_zero, a_inf, a_nan;
   logic  b_zero, b_inf, b_nan;

   assign fa = in_a;
   assign fb = in_b;

   fp32_classify u_cls_a (.op(in_a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
   fp32_classify u_cls_b (.op(in_b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

   logic               vld_p1, vld_p2;
   logic               adv_p2;

   assign adv_p2    = !vld_p2 || out_ready;
   assign in_ready  = !vld_p1 || adv_p2;
   assign out_valid = vld_p2;

   logic               sign_c;
   logic signed [9:0]  exp_c;
   logic [MANT_W-1:0]  mant_c;
   logic               guard_c, sticky_c;
   logic               spec_c, spec_inv_c;
   logic [31:0]        spec_res_c;

   assign sign_c = fa.sign ^ fb.sign;
   assign exp_c  = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'sd127
                   + (in_prod[47] ? 10'sd1 : 10'sd0);

   always_comb begin
      mant_c   = in_prod[46:23];
      guard_c  = in_prod[22];
      sticky_c = |in_prod[21:0];
      if (in_prod[47]) begin
         mant_c   = in_prod[47:24];
         guard_c  = in_prod[23];
         sticky_c = |in_prod[22:0];
      end
   end

   always_comb begin
      spec_c     = 1'b1;
      spec_inv_c = 1'b0;
      spec_res_c = QNAN;
      if (a_nan || b_nan) begin
         spec_res_c = QNAN;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         spec_res_c = QNAN;
         spec_inv_c = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_res_c = fp32_pack(sign_c, 8'hFF, '0);
      end else if (a_zero || b_zero) begin
         spec_res_c = fp32_pack(sign_c, 8'h00, '0);
      end else begin
         spec_c = 1'b0;
      end
   end

   // ---- stage 1 boundary: classify + normalize ----
   logic               sign_p1;
   logic signed [9:0]  exp_p1;
   logic [MANT_W-1:0]  mant_p1;
   logic               guard_p1, sticky_p1;
   logic               spec_p1, spec_inv_p1;
   logic [31:0]        spec_res_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        vld_p1 <= 1'b0;
      else if (in_ready) vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
         sign_p1     <= sign_c;
         exp_p1      <= exp_c;
         mant_p1     <= mant_c;
         guard_p1    <= guard_c;
         sticky_p1   <= sticky_c;
         spec_p1     <= spec_c;
         spec_inv_p1 <= spec_inv_c;
         spec_res_p1 <= spec_res_c;
      end
   end

   logic               up_c;
   logic [MANT_W:0]    mant_inc_c;
   logic [MANT_W-1:0]  mant_r_c;
   logic signed [9:0]  exp_r_c;
   logic [35:0]        pack_c;

   assign up_c       = round_up(mant_p1, guard_p1, sticky_p1);
   assign mant_inc_c = {1'b0, mant_p1} + {{MANT_W{1'b0}}, up_c};
   assign mant_r_c   = mant_inc_c[MANT_W] ? 24'h800000 : mant_inc_c[MANT_W-1:0];
   assign exp_r_c    = exp_p1 + (mant_inc_c[MANT_W] ? 10'sd1 : 10'sd0);

   always_comb begin
      pack_c = saturate_pack(sign_p1, exp_r_c, mant_r_c, guard_p1 | sticky_p1);
      if (spec_p1) pack_c = {spec_res_p1, spec_inv_p1, 3'b000};
   end

   // ---- stage 2 boundary: round + pack ----
   logic [31:0] result_p2;
   logic [3:0]  flags_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2    <= 1'b0;
         result_p2 <= '0;
         flags_p2  <= '0;
      end else if (adv_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            result_p2 <= pack_c[35:4];
            flags_p2  <= pack_c[3:0];
         end
      end
   end

   assign out_result = result_p2;
   assign out_flags  = flags_p2;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Randomized and directed bench for fp_mul_norm_round against an arithmetic reference model.
module tb_fp_mul_norm_round;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0, in_b = '0;
   logic [47:0] in_prod = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   fp_mul_norm_round dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_prod(in_prod),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [35:0] exp_q[$];
   logic        held_vld = 1'b0;
   logic [35:0] held_val;
   logic        obs_vld;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_chk++;
      if (obs === req) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, obs, req);
   endtask

   function automatic logic [47:0] mkprod(input logic [31:0] a, input logic [31:0] b);
      return 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
   endfunction

   // Reference: exact integer product, shift to 24 significant bits, nearest-even on the remainder.
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
      logic   s;
      int     ea, eb, e, sh;
      longint p, m, rem, half;
      bit     nan_a, nan_b, inf_a, inf_b, z_a, z_b, inx;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      nan_a = (ea == 255) && (a[22:0] != 0);
      nan_b = (eb == 255) && (b[22:0] != 0);
      inf_a = (ea == 255) && (a[22:0] == 0);
      inf_b = (eb == 255) && (b[22:0] == 0);
      z_a = (ea == 0);
      z_b = (eb == 0);
      if (nan_a || nan_b) return {32'h7FC00000, 4'b0000};
      if ((inf_a && z_b) || (inf_b && z_a)) return {32'h7FC00000, 4'b1000};
      if (inf_a || inf_b) return {s, 8'hFF, 23'd0, 4'b0000};
      if (z_a || z_b) return {s, 31'd0, 4'b0000};
      p  = (longint'(a[22:0]) + 64'd8388608) * (longint'(b[22:0]) + 64'd8388608);
      e  = ea + eb - 127;
      sh = 23;
      if (p >= (64'sd1 <<< 47)) begin
         sh = 24;
         e++;
      end
      m    = p >>> sh;
      rem  = p - (m <<< sh);
      half = 64'sd1 <<< (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && m[0])) m++;
      if (m == (64'sd1 <<< 24)) begin
         m = m >>> 1;
         e++;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
      if (e <= 0) return {s, 31'd0, 4'b0011};
      return {s, 8'(e), m[22:0], 3'b000, inx};
   endfunction

   // One clock: observe, drive, then account for the transfers at the coming rising edge.
   task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b, input logic ordy,
                        input bit use_req, input logic [35:0] req, output bit acc);
      logic [35:0] e;
      @(negedge clk);
      obs_vld = out_valid;
      if (held_vld) begin
         chk("hold_vld", {31'd0, out_valid}, 32'd1);
         chk("hold_res", out_result, held_val[35:4]);
         chk("hold_flg", {28'd0, out_flags}, {28'd0, held_val[3:0]});
      end
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_prod   = mkprod(a, b);
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(use_req ? req : model(a, b));
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_vld", {31'd0, out_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("res", out_result, e[35:4]);
            chk("flg", {28'd0, out_flags}, {28'd0, e[3:0]});
         end
      end
      held_vld = out_valid && !out_ready;
      held_val = {out_result, out_flags};
   endtask

   function automatic logic [31:0] rand_op();
      logic [7:0]  ex;
      logic [22:0] fr;
      case ($urandom_range(0, 9))
         0:       ex = 8'd0;
         1:       ex = 8'd255;
         2:       ex = 8'($urandom_range(190, 254));
         3:       ex = 8'($urandom_range(1, 64));
         default: ex = 8'($urandom_range(64, 190));
      endcase
      case ($urandom_range(0, 5))
         0:       fr = '0;
         1:       fr = 23'h7FFFFF;
         default: fr = 23'($urandom);
      endcase
      return {1'($urandom), ex, fr};
   endfunction

   logic [31:0] d_a[6]   = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h7F800000, 32'hFF800000};
   logic [31:0] d_b[6]   = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h00000000, 32'h40000000};
   logic [35:0] d_exp[6] = '{{32'h40100000, 4'b0000}, {32'h3F800002, 4'b0001}, {32'h7F800000, 4'b0101},
                             {32'h00000000, 4'b0011}, {32'h7FC00000, 4'b1000}, {32'hFF800000, 4'b0000}};

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit          acc;
      int          idx, guard_cnt;
      logic [31:0] sa[8], sb[8];
      logic        ord_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

      #12;
      chk("rst_vld", {31'd0, out_valid}, 32'd0);
      chk("rst_res", out_result, 32'd0);
      chk("rst_flg", {28'd0, out_flags}, 32'd0);
      chk("rst_rdy", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, d_a[i], d_b[i], 1'b1, 1'b1, d_exp[i], acc);
         chk("dir_acc", {31'd0, acc}, 32'd1);
         cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
         chk("lat_e1", {31'd0, obs_vld}, 32'd0);
         cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
         chk("lat_e2", {31'd0, obs_vld}, 32'd1);
      end

      for (int i = 0; i < 8; i++) begin
         sa[i] = rand_op();
         sb[i] = rand_op();
      end
      idx = 0;
      guard_cnt = 0;
      while (idx < 8 && guard_cnt < 100) begin
         cycle(1'b1, sa[idx], sb[idx], ord_pat[guard_cnt % 4], 1'b0, '0, acc);
         if (acc) idx++;
         guard_cnt++;
      end
      chk("stream_sent", idx, 8);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++)
         cycle(1'b0, '0, '0, ord_pat[i % 4], 1'b0, '0, acc);
      chk("stream_drain", exp_q.size(), 0);

      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom_range(0, 2) != 0),
               1'b0, '0, acc);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
      chk("rand_drain", exp_q.size(), 0);

      cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, '0, acc);
      cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, '0, acc);
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
      chk("async_rst_res", out_result, 32'd0);
      exp_q.delete();
      held_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, acc);
         chk("post_rst_idle", {31'd0, obs_vld}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
